// File: rtl/descramble_pkg.sv
// Shared constants for the 100BASE-X x^11 + x^9 + 1 stream cipher, common to
// the transmit scrambler and the receive descrambler.
package descramble_pkg;

  localparam int LFSR_W = 11;
  localparam int TAP_A  = 8;
  localparam int TAP_B  = 10;
  localparam logic [LFSR_W-1:0] LFSR_SEED = 11'h7ff;

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_CHECK  = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  // Next keystream bit for a given register contents.
  function automatic logic lfsr_key(input logic [LFSR_W-1:0] lfsr);
    return lfsr[TAP_A] ^ lfsr[TAP_B];
  endfunction

endpackage

// File: rtl/descramble.sv
// Receive-side descrambler: self-synchronises on idle (plaintext ones),
// verifies the keystream before declaring lock, and drops lock on idle loss.
module descramble
  import descramble_pkg::*;
#(
  parameter int LOCK_BITS = 30,
  parameter int TIMEOUT   = 90250,
  parameter int IDLE_RUN  = 29
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_signal_status,
  input  logic       i_scrambled,
  input  logic       i_scrambled_valid,
  output logic       o_descrambled,
  output logic       o_descrambled_valid,
  output logic       o_locked,
  output logic [1:0] o_state
);

  // Stream is valid-only (no back-pressure): a bit is consumed on every edge
  // where i_scrambled_valid is high; o_descrambled is qualified one edge later
  // by o_descrambled_valid and is meaningful as plaintext only while o_locked.

  localparam int FILL_W  = $clog2(LFSR_W + 1);
  localparam int MATCH_W = $clog2(LOCK_BITS + 1);
  localparam int TIMER_W = $clog2(TIMEOUT + 1);
  localparam int RUN_W   = $clog2(IDLE_RUN + 1);

  localparam logic [FILL_W-1:0]  FILL_MAX  = FILL_W'(LFSR_W);
  localparam logic [MATCH_W-1:0] MATCH_MAX = MATCH_W'(LOCK_BITS);
  localparam logic [TIMER_W-1:0] TIMER_MAX = TIMER_W'(TIMEOUT);
  localparam logic [RUN_W-1:0]   RUN_MAX   = RUN_W'(IDLE_RUN);

  state_t              r_state;
  logic [LFSR_W-1:0]   r_lfsr;
  logic [FILL_W-1:0]   r_fill_cnt;
  logic [MATCH_W-1:0]  r_match_cnt;
  logic [TIMER_W-1:0]  r_timer;
  logic [RUN_W-1:0]    r_run_cnt;
  logic                r_descrambled;
  logic                r_descrambled_valid;
  logic                r_locked;

  logic                w_key;
  logic                w_plain;
  logic [LFSR_W-1:0]   w_lfsr_seed;
  logic [LFSR_W-1:0]   w_lfsr_free;
  logic [FILL_W-1:0]   w_fill_inc;
  logic [MATCH_W-1:0]  w_match_inc;
  logic [TIMER_W-1:0]  w_timer_inc;
  logic [RUN_W-1:0]    w_run_inc;
  logic                w_idle_hit;

  always_comb begin
    w_key       = lfsr_key(r_lfsr);
    w_plain     = i_scrambled ^ w_key;
    // While hunting, assume idle so the cipher bit inverted is the key bit.
    w_lfsr_seed = {r_lfsr[LFSR_W-2:0], ~i_scrambled};
    w_lfsr_free = {r_lfsr[LFSR_W-2:0], w_key};
    w_fill_inc  = (r_fill_cnt  == FILL_MAX)  ? r_fill_cnt  : r_fill_cnt  + 1'b1;
    w_match_inc = (r_match_cnt == MATCH_MAX) ? r_match_cnt : r_match_cnt + 1'b1;
    w_timer_inc = (r_timer     == TIMER_MAX) ? r_timer     : r_timer     + 1'b1;
    w_run_inc   = (r_run_cnt   == RUN_MAX)   ? r_run_cnt   : r_run_cnt   + 1'b1;
    w_idle_hit  = w_plain && (w_run_inc == RUN_MAX);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state             <= ST_HUNT;
      r_lfsr              <= LFSR_SEED;
      r_fill_cnt          <= '0;
      r_match_cnt         <= '0;
      r_timer             <= '0;
      r_run_cnt           <= '0;
      r_descrambled       <= 1'b0;
      r_descrambled_valid <= 1'b0;
      r_locked            <= 1'b0;
    end else begin
      r_descrambled_valid <= i_scrambled_valid;
      if (i_scrambled_valid) begin
        r_descrambled <= w_plain;
      end
      // Signal loss overrides everything but keeps the register contents.
      if (!i_signal_status) begin
        r_state     <= ST_HUNT;
        r_locked    <= 1'b0;
        r_fill_cnt  <= '0;
        r_match_cnt <= '0;
        r_timer     <= '0;
        r_run_cnt   <= '0;
      end else if (i_scrambled_valid) begin
        case (r_state)
          ST_HUNT: begin
            r_lfsr     <= w_lfsr_seed;
            r_fill_cnt <= w_fill_inc;
            if (w_fill_inc == FILL_MAX) begin
              r_state     <= ST_CHECK;
              r_match_cnt <= '0;
            end
          end
          ST_CHECK: begin
            if (w_plain) begin
              r_lfsr      <= w_lfsr_free;
              r_match_cnt <= w_match_inc;
              if (w_match_inc == MATCH_MAX) begin
                r_state   <= ST_LOCKED;
                r_locked  <= 1'b1;
                r_timer   <= '0;
                r_run_cnt <= '0;
              end
            end else begin
              // The failing bit starts the next fill.
              r_state    <= ST_HUNT;
              r_fill_cnt <= FILL_W'(1);
              r_lfsr     <= w_lfsr_seed;
            end
          end
          ST_LOCKED: begin
            r_lfsr    <= w_lfsr_free;
            r_run_cnt <= w_plain ? w_run_inc : '0;
            if (w_idle_hit) begin
              r_timer <= '0;
            end else if (w_timer_inc == TIMER_MAX) begin
              r_state    <= ST_HUNT;
              r_locked   <= 1'b0;
              r_fill_cnt <= '0;
              r_timer    <= '0;
              r_run_cnt  <= '0;
            end else begin
              r_timer <= w_timer_inc;
            end
          end
          default: begin
            r_state  <= ST_HUNT;
            r_locked <= 1'b0;
          end
        endcase
      end
    end
  end

  assign o_descrambled       = r_descrambled;
  assign o_descrambled_valid = r_descrambled_valid;
  assign o_locked            = r_locked;
  assign o_state             = r_state;

endmodule

// File: tb/tb_descramble.sv
// Bench for descramble: a seed-7ff scrambler model drives cipher bits and the
// plaintext is queued and compared against the registered output.
module tb_descramble;
  import descramble_pkg::*;

  logic       clk;
  logic       rst;
  logic       i_signal_status;
  logic       i_scrambled;
  logic       i_scrambled_valid;
  logic       o_descrambled;
  logic       o_descrambled_valid;
  logic       o_locked;
  logic [1:0] o_state;

  logic [10:0] tx_lfsr;
  logic [1:0]  exp_q[$];
  logic        chk_on;
  int          n_checks;
  int          n_pass;
  int          n;

  descramble #(.LOCK_BITS(30), .TIMEOUT(1000), .IDLE_RUN(29)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .i_signal_status     (i_signal_status),
    .i_scrambled         (i_scrambled),
    .i_scrambled_valid   (i_scrambled_valid),
    .o_descrambled       (o_descrambled),
    .o_descrambled_valid (o_descrambled_valid),
    .o_locked            (o_locked),
    .o_state             (o_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
  endtask

  // One bit period: drive at negedge, sample 1 time unit after posedge.
  task automatic send(input logic v, input logic p, input logic sig_ok = 1'b1);
    logic       s;
    logic       key;
    logic [1:0] e;
    @(negedge clk);
    i_signal_status = sig_ok;
    if (v) begin
      key     = tx_lfsr[8] ^ tx_lfsr[10];
      s       = p ^ key;
      tx_lfsr = {tx_lfsr[9:0], key};
      exp_q.push_back({chk_on, p});
    end else begin
      s = 1'($urandom_range(0, 1));
    end
    i_scrambled       = s;
    i_scrambled_valid = v;
    @(posedge clk);
    #1;
    i_signal_status = 1'b1;
    check("desc_valid", o_descrambled_valid, v);
    if (v && exp_q.size() != 0) begin
      e = exp_q.pop_front();
      if (e[1]) check("descrambled", o_descrambled, e[0]);
    end
  endtask

  task automatic send_until_lock(input int budget, output int cnt);
    cnt = 0;
    while (!o_locked && cnt < budget) begin
      send(1'b1, 1'b1);
      cnt++;
    end
  endtask

  // Plaintext with ones-runs of at most 28: a zero every 29 bits.
  function automatic logic short_run_bit(input int i);
    return (i % 29 == 1) ? 1'b0 : 1'b1;
  endfunction

  task automatic timeout_run(input string tag);
    for (int i = 1; i <= 1000; i++) begin
      send(1'b1, short_run_bit(i));
      if (i == 999)  check({tag, "_locked_999"}, o_locked, 1'b1);
      if (i == 1000) check({tag, "_locked_1000"}, o_locked, 1'b0);
    end
    check({tag, "_state"}, o_state, 32'(ST_HUNT));
  endtask

  initial begin
    n_checks          = 0;
    n_pass            = 0;
    chk_on            = 1'b1;
    tx_lfsr           = 11'h7ff;
    rst               = 1'b1;
    i_signal_status   = 1'b1;
    i_scrambled       = 1'b0;
    i_scrambled_valid = 1'b0;

    #12;
    check("rst_desc", o_descrambled, 1'b0);
    check("rst_valid", o_descrambled_valid, 1'b0);
    check("rst_locked", o_locked, 1'b0);
    check("rst_state", o_state, 32'(ST_HUNT));
    @(negedge clk);
    rst = 1'b0;

    // Acquisition on idle: 11 fill bits + 30 verified bits.
    send_until_lock(100, n);
    check("lock_bits", n, 41);
    check("lock_state", o_state, 32'(ST_LOCKED));

    // Valid gaps: register must only advance on valid bits.
    for (int i = 0; i < 24; i++) send(i % 2 == 0, 1'($urandom_range(0, 1)));

    // /J/K/ then data.
    begin
      logic [9:0] jk;
      jk = 10'b1100010001;
      for (int i = 9; i >= 0; i--) send(1'b1, jk[i]);
    end
    for (int i = 0; i < 40; i++) send(1'b1, 1'($urandom_range(0, 1)));

    // A clean 29-one run leaves the idle timer at zero.
    send(1'b1, 1'b0);
    for (int i = 0; i < 29; i++) send(1'b1, 1'b1);
    timeout_run("timeout");

    // Relock, then a single 29-one run after 523 bits restarts the timer.
    send_until_lock(100, n);
    check("relock_bits", n, 41);
    for (int i = 1; i <= 494; i++) send(1'b1, short_run_bit(i));
    for (int i = 0; i < 29; i++) send(1'b1, 1'b1);
    check("restart_locked", o_locked, 1'b1);
    timeout_run("restart");

    // False lock: a zero at match 20 sends the FSM back to HUNT.
    for (int i = 0; i < 31; i++) send(1'b1, 1'b1);
    check("false_pre_state", o_state, 32'(ST_CHECK));
    check("false_pre_locked", o_locked, 1'b0);
    send(1'b1, 1'b0);
    check("false_state", o_state, 32'(ST_HUNT));
    check("false_locked", o_locked, 1'b0);
    // The corrupted seed bit must flush out before the check can pass.
    chk_on = 1'b0;
    send_until_lock(200, n);
    chk_on = 1'b1;
    check("false_relock_min", (n >= 40), 1'b1);
    check("false_relock_max", (n <= 55), 1'b1);
    for (int i = 0; i < 20; i++) send(1'b1, 1'($urandom_range(0, 1)));

    // Signal loss together with a valid bit: loss wins, bit still decodes.
    send(1'b1, 1'b1, 1'b0);
    check("loss_locked", o_locked, 1'b0);
    check("loss_state", o_state, 32'(ST_HUNT));
    chk_on = 1'b0;
    send_until_lock(100, n);
    chk_on = 1'b1;
    check("loss_relock_bits", n, 41);
    for (int i = 0; i < 16; i++) send(1'b1, 1'($urandom_range(0, 1)));

    // Loss without a valid bit, then reset mid-CHECK.
    send(1'b0, 1'b0, 1'b0);
    check("loss2_locked", o_locked, 1'b0);
    for (int i = 0; i < 20; i++) send(1'b1, 1'b1);
    check("pre_rst_state", o_state, 32'(ST_CHECK));
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_desc", o_descrambled, 1'b0);
    check("async_rst_valid", o_descrambled_valid, 1'b0);
    check("async_rst_locked", o_locked, 1'b0);
    check("async_rst_state", o_state, 32'(ST_HUNT));
    check("async_rst_lfsr", dut.r_lfsr, 11'h7ff);
    rst = 1'b0;
    chk_on = 1'b0;
    send_until_lock(100, n);
    chk_on = 1'b1;
    check("rst_relock_bits", n, 41);
    for (int i = 0; i < 16; i++) send(1'b1, 1'($urandom_range(0, 1)));
    check("queue_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
